// File: rtl/monitor_bus_pkg.sv
// Shared constants and FSM encoding for the option-slot bus initiator.
package monitor_bus_pkg;
  localparam logic [7:0] CMD_IRQ       = 8'h02;
  localparam logic [7:0] CMD_INIT      = 8'h10;
  localparam logic [7:0] CMD_ID        = 8'h20;
  localparam logic [7:0] CMD_VIDEO     = 8'h21;
  localparam logic [7:0] CMD_PREPARE   = 8'h22;
  localparam logic [7:0] CMD_SERIAL    = 8'h23;
  localparam logic [7:0] BUS_IDLE_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_REG, ST_DATA, ST_DESEL, ST_RESP
  } state_e;

  // Read counter increment that sticks at FF.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/bus_phase_timer.sv
// clk_rw divider: HALF_DIV clocks low then HALF_DIV clocks high per bus cycle.
module bus_phase_timer #(
  parameter int HALF_DIV = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_clk_rw,
  output logic o_low_start,
  output logic o_high_end
);
  localparam logic [7:0] LAST = 8'(HALF_DIV - 1);

  logic [7:0] r_cnt;
  logic       r_phase;

  // Half-period counter; held in the low-half start position while disabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (!i_en) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_clk_rw    = r_phase;
  assign o_low_start = i_en & ~r_phase & (r_cnt == 8'd0);
  assign o_high_end  = i_en &  r_phase & (r_cnt == LAST);
endmodule

// File: rtl/monitor_bus_initiator.sv
// Monitor-side initiator: one host request -> cmd/reg/data/deselect bus cycles,
// with optional busy-polling of a read until a target value is returned.
module monitor_bus_initiator
  import monitor_bus_pkg::*;
#(
  parameter int HALF_DIV = 10,
  parameter int POLL_MAX = 64
) (
  input  logic       clk_20mhz,
  input  logic       reset_x,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_cmd,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  input  logic       req_write,
  input  logic       req_poll,
  input  logic [7:0] req_poll_val,
  input  logic       req_slot_sel,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_timeout,
  output logic [7:0] rsp_reads,
  output logic       clk_rw,
  output logic       ax_d,
  output logic       r_wx,
  output logic       slot_x_int_x,
  output logic [7:0] bus_data_out,
  output logic       bus_data_oe_x,
  input  logic [7:0] bus_data_in,
  input  logic       int_x,
  output logic       irq_pending
);
  localparam logic [7:0] PMAX = 8'(POLL_MAX);

  state_e     r_state, w_state_nxt;
  logic       r_started;
  logic [7:0] r_cmd, r_reg, r_wdata, r_pval;
  logic       r_write, r_poll, r_sel;
  logic [7:0] r_rdata, r_reads;
  logic       r_timeout;
  logic       r_sync1, r_sync2;
  logic       w_busy, w_low_start, w_high_end, w_accept;
  logic       w_rd_data, w_miss, w_retry;

  assign w_busy    = (r_state == ST_CMD) || (r_state == ST_REG) ||
                     (r_state == ST_DATA) || (r_state == ST_DESEL);
  assign w_accept  = req_valid & req_ready;
  // Poll on a write degenerates to a plain write.
  assign w_rd_data = (r_state == ST_DATA) & ~r_write;
  assign w_miss    = r_poll & (bus_data_in != r_pval);
  // r_reads already counts the read in flight (incremented at its low start).
  assign w_retry   = w_miss & (r_reads < PMAX);

  bus_phase_timer #(.HALF_DIV(HALF_DIV)) u_timer (
    .i_clk      (clk_20mhz),
    .i_rst_n    (reset_x),
    .i_en       (w_busy),
    .o_clk_rw   (clk_rw),
    .o_low_start(w_low_start),
    .o_high_end (w_high_end)
  );

  // State register.
  always_ff @(posedge clk_20mhz or negedge reset_x) begin
    if (!reset_x) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and bus levels; levels only move with state, i.e. at low-half start.
  always_comb begin
    w_state_nxt   = r_state;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    ax_d          = 1'b0;
    r_wx          = 1'b1;
    bus_data_out  = BUS_IDLE_BYTE;
    bus_data_oe_x = 1'b1;
    slot_x_int_x  = 1'b1;
    case (r_state)
      ST_IDLE: begin
        req_ready = r_started;
        if (req_valid && r_started) w_state_nxt = ST_CMD;
      end
      ST_CMD: begin
        bus_data_out  = r_cmd;
        bus_data_oe_x = 1'b0;
        slot_x_int_x  = ~r_sel;
        if (w_high_end) w_state_nxt = ST_REG;
      end
      ST_REG: begin
        r_wx          = ~r_write;
        bus_data_out  = r_reg;
        bus_data_oe_x = 1'b0;
        slot_x_int_x  = ~r_sel;
        if (w_high_end) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        ax_d         = 1'b1;
        slot_x_int_x = ~r_sel;
        if (r_write) begin
          r_wx          = 1'b0;
          bus_data_out  = r_wdata;
          bus_data_oe_x = 1'b0;
        end
        if (w_high_end) w_state_nxt = (!r_write && w_retry) ? ST_CMD : ST_DESEL;
      end
      ST_DESEL: begin
        r_wx          = 1'b0;
        bus_data_oe_x = 1'b0;
        slot_x_int_x  = ~r_sel;
        if (w_high_end) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, read counter and response registers.
  always_ff @(posedge clk_20mhz or negedge reset_x) begin
    if (!reset_x) begin
      r_started <= 1'b0;
      r_cmd     <= '0;
      r_reg     <= '0;
      r_wdata   <= '0;
      r_pval    <= '0;
      r_write   <= 1'b0;
      r_poll    <= 1'b0;
      r_sel     <= 1'b0;
      r_rdata   <= BUS_IDLE_BYTE;
      r_reads   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_started <= 1'b1;
      if (w_accept) begin
        r_cmd     <= req_cmd;
        r_reg     <= req_reg;
        r_wdata   <= req_wdata;
        r_pval    <= req_poll_val;
        r_write   <= req_write;
        r_poll    <= req_poll;
        r_sel     <= req_slot_sel;
        r_rdata   <= BUS_IDLE_BYTE;
        r_reads   <= '0;
        r_timeout <= 1'b0;
      end
      if (w_rd_data && w_low_start) r_reads <= sat_inc(r_reads);
      if (w_rd_data && w_high_end) begin
        r_rdata <= bus_data_in;
        if (w_miss && !w_retry) r_timeout <= 1'b1;
      end
    end
  end

  // Two-flop synchroniser on the active-low card interrupt.
  always_ff @(posedge clk_20mhz or negedge reset_x) begin
    if (!reset_x) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= ~int_x;
      r_sync2 <= r_sync1;
    end
  end

  assign rsp_rdata   = r_rdata;
  assign rsp_timeout = r_timeout;
  assign rsp_reads   = r_reads;
  assign irq_pending = r_sync2;
endmodule

// File: tb/tb_monitor_bus_initiator.sv
// Scoreboard bench: drivers push expected bus bytes / responses, monitors pop and compare.
module tb_monitor_bus_initiator;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       req_valid = 1'b0, req_valid2 = 1'b0;
  logic       req_ready, req_ready2;
  logic [7:0] req_cmd = '0, req_reg = '0, req_wdata = '0, req_poll_val = '0;
  logic       req_write = 1'b0, req_poll = 1'b0, req_slot_sel = 1'b0;
  logic       rsp_valid, rsp_timeout, rsp_valid2, rsp_timeout2;
  logic [7:0] rsp_rdata, rsp_reads, rsp_rdata2, rsp_reads2;
  logic       clk_rw, ax_d, r_wx, slot_x, bus_oe_x, irq;
  logic       clk_rw2, ax_d2, r_wx2, slot2, oe2, irq2;
  logic [7:0] bus_dout, dout2;
  logic [7:0] bus_din = 8'h5A;
  logic       int_x = 1'b1;

  typedef struct {
    logic [7:0] rdata; logic to; logic [7:0] reads; int lat; int slow;
  } rsp_t;
  rsp_t        rsp_q[$], rsp2_q[$];
  logic [10:0] bus_q[$];
  logic [7:0]  card_q[$];
  bit          bus_mon_en = 1'b0;
  int          vec = 0, err = 0, cyc = 0;
  int          acc = 0, acc2 = 0, slow = 0;

  monitor_bus_initiator #(.HALF_DIV(10), .POLL_MAX(64)) dut (
    .clk_20mhz(clk), .reset_x(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_reg(req_reg), .req_wdata(req_wdata), .req_write(req_write),
    .req_poll(req_poll), .req_poll_val(req_poll_val), .req_slot_sel(req_slot_sel),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .rsp_reads(rsp_reads), .clk_rw(clk_rw), .ax_d(ax_d), .r_wx(r_wx),
    .slot_x_int_x(slot_x), .bus_data_out(bus_dout), .bus_data_oe_x(bus_oe_x),
    .bus_data_in(bus_din), .int_x(int_x), .irq_pending(irq));

  monitor_bus_initiator #(.HALF_DIV(2), .POLL_MAX(4)) dut4 (
    .clk_20mhz(clk), .reset_x(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_cmd(req_cmd), .req_reg(req_reg), .req_wdata(req_wdata), .req_write(req_write),
    .req_poll(req_poll), .req_poll_val(req_poll_val), .req_slot_sel(req_slot_sel),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_timeout(rsp_timeout2),
    .rsp_reads(rsp_reads2), .clk_rw(clk_rw2), .ax_d(ax_d2), .r_wx(r_wx2),
    .slot_x_int_x(slot2), .bus_data_out(dout2), .bus_data_oe_x(oe2),
    .bus_data_in(8'h29), .int_x(1'b1), .irq_pending(irq2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    vec++; err++;
    $display("FAIL %s: event with nothing expected", nm);
  endtask

  task automatic pushb(input logic ax, input logic rw, input logic oe, input logic [7:0] d);
    bus_q.push_back({ax, rw, oe, d});
  endtask

  task automatic pushr(input logic [7:0] rd, input logic to, input logic [7:0] n,
                       input int lat, input int sl, input bit two);
    rsp_t e;
    e.rdata = rd; e.to = to; e.reads = n; e.lat = lat; e.slow = sl;
    if (two) rsp2_q.push_back(e); else rsp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] r, input logic [7:0] w,
                      input logic wr, input logic p, input logic [7:0] pv,
                      input logic sel, input bit two);
    @(posedge clk); #1;
    req_cmd = c; req_reg = r; req_wdata = w; req_write = wr;
    req_poll = p; req_poll_val = pv; req_slot_sel = sel;
    if (two) req_valid2 = 1'b1; else req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_valid2 = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((rsp_q.size() != 0 || rsp2_q.size() != 0 || bus_q.size() != 0) && t < 20000) begin
      @(negedge clk); t++;
    end
    if (t >= 20000) begin
      vec++; err++;
      $display("FAIL wait_done: timed out, rsp %0d bus %0d pending", rsp_q.size(), bus_q.size());
      rsp_q.delete(); rsp2_q.delete(); bus_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  // Card model: present the next queued byte for each read data cycle.
  always @(posedge clk_rw)
    if (ax_d && r_wx) bus_din = (card_q.size() != 0) ? card_q.pop_front() : 8'h5A;

  // Bus monitor: each byte the card would sample on clk_rw high.
  always @(posedge clk_rw)
    if (bus_mon_en) begin
      if (bus_q.size() == 0) miss("bus_byte");
      else chk("bus_byte{ax,rw,oe,d}", {ax_d, r_wx, bus_oe_x, bus_dout}, bus_q.pop_front());
    end

  // Response monitor, main instance.
  always @(negedge clk) begin
    rsp_t e;
    if (req_valid && req_ready) begin acc = cyc; slow = 0; end
    else if (!slot_x) slow++;
    if (rsp_valid) begin
      if (rsp_q.size() == 0) miss("rsp_valid");
      else begin
        e = rsp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_timeout", rsp_timeout, e.to);
        chk("rsp_reads", rsp_reads, e.reads);
        chk("latency", cyc - acc, e.lat);
        chk("slot_low_clks", slow, e.slow);
        chk("slot_in_resp", slot_x, 1'b1);
      end
    end
  end

  // Response monitor, POLL_MAX=4 instance.
  always @(negedge clk) begin
    rsp_t e;
    if (req_valid2 && req_ready2) acc2 = cyc;
    if (rsp_valid2) begin
      if (rsp2_q.size() == 0) miss("rsp_valid2");
      else begin
        e = rsp2_q.pop_front();
        chk("rsp2_rdata", rsp_rdata2, e.rdata);
        chk("rsp2_timeout", rsp_timeout2, e.to);
        chk("rsp2_reads", rsp_reads2, e.reads);
        chk("latency2", cyc - acc2, e.lat);
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_bus{clk,ax,rw,slot,oe,d}", {clk_rw, ax_d, r_wx, slot_x, bus_oe_x, bus_dout},
        {5'b00111, 8'hFF});
    chk("rst_rsp{v,to,rd,n}", {rsp_valid, rsp_timeout, rsp_rdata, rsp_reads}, {2'b00, 8'hFF, 8'h00});
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_irq", irq, 1'b0);
    rst_n = 1'b1; #1;
    chk("ready_before_clock", req_ready, 1'b0);
    @(posedge clk); #1;
    chk("ready_after_clock", req_ready, 1'b1);
    chk("ready2_after_clock", req_ready2, 1'b1);
    bus_mon_en = 1'b1;

    // Write 22/25/A0
    pushb(0,1,0,8'h22); pushb(0,0,0,8'h25); pushb(1,0,0,8'hA0); pushb(0,0,0,8'hFF);
    pushr(8'hFF, 0, 8'd0, 81, 0, 0);
    send(8'h22, 8'h25, 8'hA0, 1, 0, 8'h00, 0, 0);
    wait_done();

    // Read 23/00, card returns 88
    card_q.push_back(8'h88);
    pushb(0,1,0,8'h23); pushb(0,1,0,8'h00); pushb(1,1,1,8'hFF); pushb(0,0,0,8'hFF);
    pushr(8'h88, 0, 8'd1, 81, 0, 0);
    send(8'h23, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0);
    wait_done();

    // Poll 22/27 until 00: 09 x12 then 00
    for (int i = 0; i < 12; i++) card_q.push_back(8'h09);
    card_q.push_back(8'h00);
    for (int i = 0; i < 13; i++) begin
      pushb(0,1,0,8'h22); pushb(0,1,0,8'h27); pushb(1,1,1,8'hFF);
    end
    pushb(0,0,0,8'hFF);
    pushr(8'h00, 0, 8'd13, 8*10 + 12*6*10 + 1, 0, 0);
    send(8'h22, 8'h27, 8'h00, 0, 1, 8'h00, 0, 0);
    wait_done();

    // Poll with write set behaves as a plain write
    pushb(0,1,0,8'h21); pushb(0,0,0,8'h30); pushb(1,0,0,8'h44); pushb(0,0,0,8'hFF);
    pushr(8'hFF, 0, 8'd0, 81, 0, 0);
    send(8'h21, 8'h30, 8'h44, 1, 1, 8'h00, 0, 0);
    wait_done();

    // POLL_MAX=4, card always 29: timeout after 4 reads (HALF_DIV=2)
    pushr(8'h29, 1, 8'd4, 8*2 + 3*6*2 + 1, 0, 1);
    send(8'h22, 8'h27, 8'h00, 0, 1, 8'h00, 0, 1);
    wait_done();

    // Init 10/03/05 with slot select: slot low for all 4 bus cycles
    pushb(0,1,0,8'h10); pushb(0,0,0,8'h03); pushb(1,0,0,8'h05); pushb(0,0,0,8'hFF);
    pushr(8'hFF, 0, 8'd0, 81, 80, 0);
    send(8'h10, 8'h03, 8'h05, 1, 0, 8'h00, 1, 0);
    wait_done();

    // Reset during REG cycle
    bus_mon_en = 1'b0;
    send(8'h22, 8'h25, 8'hA0, 1, 0, 8'h00, 1, 0);
    repeat (22) @(posedge clk); #1;
    chk("mid_reg{ax,rw,slot,d}", {ax_d, r_wx, slot_x, bus_dout}, {3'b000, 8'h25});
    rst_n = 1'b0; #1;
    chk("abort_bus{clk,ax,rw,slot,oe,d}", {clk_rw, ax_d, r_wx, slot_x, bus_oe_x, bus_dout},
        {5'b00111, 8'hFF});
    chk("abort_ready", req_ready, 1'b0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (120) @(posedge clk); #1;
    chk("abort_rsp{to,rd,n}", {rsp_timeout, rsp_rdata, rsp_reads}, {1'b0, 8'hFF, 8'h00});
    chk("abort_ready_after", req_ready, 1'b1);
    bus_mon_en = 1'b1;

    // int_x low for 3 clocks
    @(posedge clk); #1; int_x = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("irq_pending[%0d]", i), irq, (i >= 2 && i <= 4) ? 1'b1 : 1'b0);
      if (i == 2) begin @(posedge clk); #1; int_x = 1'b1; end
    end

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
